// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- control unit for a 5-stage pipeline.
//
// Decodes the ID-stage instruction into a control bundle. The bundle then
// moves through the ID/EX, EX/MEM and MEM/WB registers. The block also
// detects load-use hazards and sequences branch/jump redirects and flushes.
//
// Parameters:
//   ALUOP_W       ALU-op field width (3..6, upper bits zero)
//   REG_W         register-address width
//   FLUSH_CYCLES  cycles of IF/ID flush per redirect (1..4)
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-high reset
//   opcode, func       ID-stage instruction fields
//   compare_result     ID-stage register equality, used by beq/bne
//   id_rs, id_rt       ID-stage source registers
//   ex_ctrl            {alusrc, aluop, regdst} for the EX stage
//   mem_ctrl           {mem_read, mem_write} for the MEM stage
//   wb_ctrl            {reg_write, mem_to_reg} for the WB stage
//   pc_src             00 PC+4, 01 jump, 10 branch
//   flush              kill the IF/ID contents
//   pc_write           PC load enable
//   ifid_write         IF/ID load enable
//
// Optional feature: define PIPE_CTRL_IMM_OPS_EN to decode addi/slti/andi/ori.
// When the macro is undefined, those opcodes decode as bubbles.

module pipe_ctrl #(
    parameter int ALUOP_W      = 3,
    parameter int REG_W        = 5,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func,
    input  logic               compare_result,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    output logic [ALUOP_W+1:0] ex_ctrl,
    output logic [1:0]         mem_ctrl,
    output logic [1:0]         wb_ctrl,
    output logic [1:0]         pc_src,
    output logic               flush,
    output logic               pc_write,
    output logic               ifid_write
);

    typedef struct packed {
        logic               alusrc;
        logic [ALUOP_W-1:0] aluop;
        logic               regdst;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic               mem_to_reg;
    } ctrl_t;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } state_t;

    state_t           state, state_n;
    logic [2:0]       cnt, cnt_n;
    ctrl_t            dec, idex, idex_n;
    logic [3:0]       exmem;      // {mem_read, mem_write, reg_write, mem_to_reg}
    logic [1:0]       memwb;      // {reg_write, mem_to_reg}
    logic [REG_W-1:0] ex_rt;
    logic             ex_mem_read;

    logic uses_rt;
    logic is_jump, is_beq, is_bne, taken, hazard;

    // ID-stage decode
    always_comb begin
        dec     = '0;
        uses_rt = 1'b0;
        is_jump = 1'b0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        case (opcode)
            6'b000000: begin
                uses_rt = 1'b1;
                case (func)
                    6'b100000: dec.aluop = ALUOP_W'(3'b001);
                    6'b100010: dec.aluop = ALUOP_W'(3'b010);
                    6'b100100: dec.aluop = ALUOP_W'(3'b011);
                    6'b100101: dec.aluop = ALUOP_W'(3'b100);
                    6'b101010: dec.aluop = ALUOP_W'(3'b101);
                    default:   dec.aluop = '0;
                endcase
                if (dec.aluop != '0) begin
                    dec.regdst    = 1'b1;
                    dec.reg_write = 1'b1;
                end
            end
            6'b100011: begin
                dec.aluop      = ALUOP_W'(3'b001);
                dec.alusrc     = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
            end
            6'b101011: begin
                uses_rt       = 1'b1;
                dec.aluop     = ALUOP_W'(3'b001);
                dec.alusrc    = 1'b1;
                dec.mem_write = 1'b1;
            end
            6'b000010: is_jump = 1'b1;
            6'b000100: begin
                uses_rt = 1'b1;
                is_beq  = 1'b1;
            end
            6'b000101: begin
                uses_rt = 1'b1;
                is_bne  = 1'b1;
            end
`ifdef PIPE_CTRL_IMM_OPS_EN
            6'b001000: begin
                dec.aluop     = ALUOP_W'(3'b001);
                dec.alusrc    = 1'b1;
                dec.reg_write = 1'b1;
            end
            6'b001010: begin
                dec.aluop     = ALUOP_W'(3'b101);
                dec.alusrc    = 1'b1;
                dec.reg_write = 1'b1;
            end
            6'b001100: begin
                dec.aluop     = ALUOP_W'(3'b011);
                dec.alusrc    = 1'b1;
                dec.reg_write = 1'b1;
            end
            6'b001101: begin
                dec.aluop     = ALUOP_W'(3'b100);
                dec.alusrc    = 1'b1;
                dec.reg_write = 1'b1;
            end
`endif
            default: dec = '0;
        endcase
    end

    assign taken  = (is_beq && compare_result) || (is_bne && !compare_result);
    assign hazard = (state == RUN) && ex_mem_read && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || ((ex_rt == id_rt) && uses_rt));

    // Next state and stage controls. STALL behaves like RUN with hazard
    // detection masked, so a redirect held behind a stall is taken there.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        idex_n     = dec;
        pc_src     = 2'b00;
        flush      = 1'b0;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        case (state)
            FLUSH: begin
                flush  = 1'b1;
                idex_n = '0;
                cnt_n  = cnt - 3'd1;
                if (cnt <= 3'd1) state_n = RUN;
            end
            default: begin
                state_n = RUN;
                if (hazard) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_n     = '0;
                    state_n    = STALL;
                end else if (is_jump || is_beq || is_bne) begin
                    idex_n = '0;
                    if (is_jump) begin
                        pc_src = 2'b01;
                        flush  = 1'b1;
                    end else if (taken) begin
                        pc_src = 2'b10;
                        flush  = 1'b1;
                    end
                    if ((is_jump || taken) && (FLUSH_CYCLES > 1)) begin
                        state_n = FLUSH;
                        cnt_n   = 3'(FLUSH_CYCLES - 1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            cnt         <= '0;
            idex        <= '0;
            exmem       <= '0;
            memwb       <= '0;
            ex_rt       <= '0;
            ex_mem_read <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idex        <= idex_n;
            ex_rt       <= id_rt;
            ex_mem_read <= idex_n.mem_read;
            exmem       <= {idex.mem_read, idex.mem_write, idex.reg_write, idex.mem_to_reg};
            memwb       <= exmem[1:0];
        end
    end

    assign ex_ctrl  = {idex.alusrc, idex.aluop, idex.regdst};
    assign mem_ctrl = exmem[3:2];
    assign wb_ctrl  = memwb;

endmodule
